// File: rtl/ucsbece154a_mc_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: state codes, opcodes,
// ALUOp classes and the mux/ALU select encodings seen by the datapath.
package ucsbece154a_mc_controller_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_FETCH    = 4'd0;
  localparam state_t ST_DECODE   = 4'd1;
  localparam state_t ST_MEMADR   = 4'd2;
  localparam state_t ST_MEMREAD  = 4'd3;
  localparam state_t ST_MEMWB    = 4'd4;
  localparam state_t ST_MEMWRITE = 4'd5;
  localparam state_t ST_EXECR    = 4'd6;
  localparam state_t ST_EXECI    = 4'd7;
  localparam state_t ST_ALUWB    = 4'd8;
  localparam state_t ST_JAL      = 4'd9;
  localparam state_t ST_BEQ      = 4'd10;
  localparam state_t ST_LUI      = 4'd11;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // ALUOp classes: address/increment arithmetic, branch compare, funct3-driven
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_OTHER = 2'b10;

  localparam logic [2:0] ALUCTRL_ADD = 3'b000;
  localparam logic [2:0] ALUCTRL_SUB = 3'b001;
  localparam logic [2:0] ALUCTRL_AND = 3'b010;
  localparam logic [2:0] ALUCTRL_OR  = 3'b011;
  localparam logic [2:0] ALUCTRL_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format is a pure function of the opcode, independent of state
  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      OP_LW, OP_ITYPE: imm_src = IMM_I;
      OP_SW:           imm_src = IMM_S;
      OP_BEQ:          imm_src = IMM_B;
      OP_JAL:          imm_src = IMM_J;
      OP_LUI:          imm_src = IMM_U;
      default:         imm_src = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ucsbece154a_aludec.sv
// ALU decoder: maps ALUOp class plus funct3/funct7 to the ALU operation.
// Kept standalone so the single-cycle controller can share it.
module ucsbece154a_aludec
  import ucsbece154a_mc_controller_pkg::*;
(
  input  logic [1:0] ALUOp_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] ALUControl_o
);

  // Decode ALU operation; unknown funct3 falls back to add so nothing goes X
  always_comb begin
    ALUControl_o = ALUCTRL_ADD;
    case (ALUOp_i)
      ALUOP_BEQ: ALUControl_o = ALUCTRL_SUB;
      ALUOP_OTHER: begin
        case (funct3_i)
          // op5 separates R-type sub from addi, whose bit 30 is immediate data
          F3_ADDSUB: ALUControl_o = (funct7b5_i & op5_i) ? ALUCTRL_SUB : ALUCTRL_ADD;
          F3_SLT:    ALUControl_o = ALUCTRL_SLT;
          F3_OR:     ALUControl_o = ALUCTRL_OR;
          F3_AND:    ALUControl_o = ALUCTRL_AND;
          default:   ALUControl_o = ALUCTRL_ADD;
        endcase
      end
      default: ALUControl_o = ALUCTRL_ADD;
    endcase
  end

endmodule

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle RV32I controller: Moore FSM driving the shared-memory datapath
// through fetch/decode/execute/memory/writeback, stalling on MemReady_i.
module ucsbece154a_mc_controller
  import ucsbece154a_mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       Zero_i,
  input  logic       MemReady_i,
  output logic       PCWrite_o,
  output logic       AdrSrc_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALUControl_o,
  output logic [2:0] ImmSrc_o,
  output logic       RegWrite_o,
  output logic [3:0] state_o
);

  state_t     state_reg;
  state_t     state_next;
  logic       pc_update;
  logic       branch;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_op;

  // State register; reset drops straight back to FETCH, abandoning any instruction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= ST_FETCH;
    else       state_reg <= state_next;
  end

  // Next-state sequencing, holding memory states until the access completes
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:    if (MemReady_i) state_next = ST_DECODE;
      ST_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_EXECR;
          OP_ITYPE:     state_next = ST_EXECI;
          OP_JAL:       state_next = ST_JAL;
          OP_BEQ:       state_next = ST_BEQ;
          OP_LUI:       state_next = ST_LUI;
          default:      state_next = ST_FETCH;
        endcase
      end
      ST_MEMADR:   state_next = (op_i == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (MemReady_i) state_next = ST_MEMWB;
      ST_MEMWRITE: if (MemReady_i) state_next = ST_FETCH;
      ST_EXECR,
      ST_EXECI,
      ST_JAL:      state_next = ST_ALUWB;
      default:     state_next = ST_FETCH;
    endcase
  end

  // Per-state control word; anything not set for a state stays 0
  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    AdrSrc_o    = 1'b0;
    ResultSrc_o = RES_ALUOUT;
    ALUSrcA_o   = SRCA_PC;
    ALUSrcB_o   = SRCB_B;
    alu_op      = ALUOP_MEM;
    case (state_reg)
      ST_FETCH: begin
        ir_write    = 1'b1;
        ALUSrcB_o   = SRCB_FOUR;
        ResultSrc_o = RES_ALURESULT;
        pc_update   = MemReady_i;
      end
      ST_DECODE: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
      end
      ST_MEMADR: begin
        ALUSrcA_o = SRCA_A;
        ALUSrcB_o = SRCB_IMM;
      end
      ST_MEMREAD:  AdrSrc_o = 1'b1;
      ST_MEMWB: begin
        ResultSrc_o = RES_DATA;
        reg_write   = 1'b1;
      end
      ST_MEMWRITE: begin
        AdrSrc_o  = 1'b1;
        mem_write = 1'b1;
      end
      ST_EXECR: begin
        ALUSrcA_o = SRCA_A;
        alu_op    = ALUOP_OTHER;
      end
      ST_EXECI: begin
        ALUSrcA_o = SRCA_A;
        ALUSrcB_o = SRCB_IMM;
        alu_op    = ALUOP_OTHER;
      end
      ST_ALUWB:    reg_write = 1'b1;
      ST_JAL: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_FOUR;
        pc_update = 1'b1;
      end
      ST_BEQ: begin
        ALUSrcA_o = SRCA_A;
        alu_op    = ALUOP_BEQ;
        branch    = 1'b1;
      end
      ST_LUI: begin
        ResultSrc_o = RES_IMMEXT;
        reg_write   = 1'b1;
      end
      default: ;
    endcase
  end

  ucsbece154a_aludec u_aludec (
    .ALUOp_i      (alu_op),
    .funct3_i     (funct3_i),
    .funct7b5_i   (funct7b5_i),
    .op5_i        (op_i[5]),
    .ALUControl_o (ALUControl_o)
  );

  // Write enables are masked by rstn so none can pulse while reset is held
  assign PCWrite_o  = rstn & (pc_update | (branch & Zero_i));
  assign IRWrite_o  = rstn & ir_write;
  assign MemWrite_o = rstn & mem_write;
  assign RegWrite_o = rstn & reg_write;
  assign ImmSrc_o   = imm_src(op_i);
  assign state_o    = state_reg;

endmodule
